// File: rtl/wts_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module : wts_mixer_pkg
// Brief  : Shared widths and slot encodings for the 5-slot channel mixer.
// Rev    : 1.0  initial release
// ============================================================================
package wts_mixer_pkg;

    localparam int          WTS_SLOT_NUM = 5;
    localparam logic [2:0]  WTS_SLOT_NOP = 3'd5;
    localparam int          WAVE_W       = 8;
    localparam int          ENV_W        = 7;
    localparam int          VOL_W        = 4;
    localparam int          ACC_W        = 15;
    localparam int          TERM_W       = 12;

endpackage
`default_nettype wire

// File: rtl/wts_saturate.sv
`default_nettype none
// ============================================================================
// Module : wts_saturate
// Brief  : Clamps a signed value to a narrower signed range and flags clipping.
// Rev    : 1.0  initial release
// ============================================================================
module wts_saturate
    import wts_mixer_pkg::*;
#(
    parameter int IN_W  = 15,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    // Output range bounds expressed at input width; ~max is exactly -2^(OUT_W-1).
    localparam logic signed [IN_W-1:0] c_max = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] c_min = ~c_max;

    always_comb begin
        dout = din[OUT_W-1:0];
        clip = 1'b0;
        if (din > c_max) begin
            dout = c_max[OUT_W-1:0];
            clip = 1'b1;
        end else if (din < c_min) begin
            dout = c_min[OUT_W-1:0];
            clip = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wts_channel_mixer_5ch.sv
`default_nettype none
// ============================================================================
// Module : wts_channel_mixer_5ch
// Brief  : Time-multiplexed 5-slot mixer: per-slot envelope/volume scaling,
//          frame accumulation and saturated mix output once per frame.
// Rev    : 1.0  initial release
// ============================================================================
module wts_channel_mixer_5ch
    import wts_mixer_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [2:0]               active,
    input  logic signed [WAVE_W-1:0] wave,
    input  logic [ENV_W-1:0]         envelope,
    input  logic [VOL_W-1:0]         reg_volume,
    input  logic                     ch_mute,
    output logic signed [OUT_W-1:0]  mix_out,
    output logic                     mix_valid,
    output logic                     mix_clip
);

    logic signed [2*WAVE_W-1:0] w_prod;
    logic signed [2*WAVE_W-1:0] w_scaled;
    logic signed [TERM_W-1:0]   w_term;
    logic [2:0]                 w_tag;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [OUT_W-1:0]    w_sat;
    logic                       w_clip;

    logic signed [TERM_W-1:0]   r_term;
    logic [2:0]                 r_tag;
    logic signed [ACC_W-1:0]    r_acc;

    // Envelope is unsigned, so it is zero-extended before the signed multiply;
    // the arithmetic shift floors toward minus infinity.
    assign w_prod   = wave * $signed({1'b0, envelope});
    assign w_scaled = w_prod >>> ENV_W;
    assign w_term   = TERM_W'(w_scaled * $signed({1'b0, reg_volume}));
    assign w_tag    = (active < 3'(WTS_SLOT_NUM)) ? active : WTS_SLOT_NOP;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_term <= '0;
            r_tag  <= WTS_SLOT_NOP;
        end else begin
            r_term <= ch_mute ? '0 : w_term;
            r_tag  <= w_tag;
        end
    end

    assign w_sum = r_acc + ACC_W'(r_term);

    wts_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .din  (w_sum),
        .dout (w_sat),
        .clip (w_clip)
    );

    // Slot 0 always opens a fresh frame; slot 4 closes it and clears the sum.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc     <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            mix_clip  <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            case (r_tag)
                3'd0: r_acc <= ACC_W'(r_term);
                3'd1, 3'd2, 3'd3: r_acc <= w_sum;
                3'd4: begin
                    mix_out   <= w_sat;
                    mix_clip  <= w_clip;
                    mix_valid <= 1'b1;
                    r_acc     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wts_channel_mixer_5ch.sv
`default_nettype none
// ============================================================================
// Module : tb_wts_channel_mixer_5ch
// Brief  : Scoreboard bench for the 5-slot channel mixer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wts_channel_mixer_5ch;

    localparam int OUT_W = 12;
    localparam int SMAX  = (1 << (OUT_W - 1)) - 1;
    localparam int SMIN  = -(1 << (OUT_W - 1));

    typedef struct {
        int val;
        bit clip;
        int cyc;
    } res_t;

    logic                    clk;
    logic                    nreset;
    logic [2:0]              active;
    logic signed [7:0]       wave;
    logic [6:0]              envelope;
    logic [3:0]              reg_volume;
    logic                    ch_mute;
    logic signed [OUT_W-1:0] mix_out;
    logic                    mix_valid;
    logic                    mix_clip;

    res_t exp_q[$];
    res_t obs[128];
    int   n_obs = 0;
    int   rd    = 0;
    int   cyc   = 0;
    int   m_acc = 0;
    int   total = 0;
    int   bad   = 0;

    wts_channel_mixer_5ch #(.OUT_W(OUT_W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .active     (active),
        .wave       (wave),
        .envelope   (envelope),
        .reg_volume (reg_volume),
        .ch_mute    (ch_mute),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .mix_clip   (mix_clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nreset && mix_valid && n_obs < 128) begin
            obs[n_obs] <= '{val: int'(mix_out), clip: mix_clip, cyc: cyc};
            n_obs      <= n_obs + 1;
        end
    end

    // Drives one slot for one cycle and advances the reference frame model.
    task automatic drive_slot(input int slot, input int w, input int e, input int v, input bit m);
        int   p, sc, t, sum;
        res_t r;
        active     = 3'(slot);
        wave       = 8'(w);
        envelope   = 7'(e);
        reg_volume = 4'(v);
        ch_mute    = m;
        p  = w * e;
        sc = (p >= 0) ? p / 128 : -((-p + 127) / 128);
        t  = m ? 0 : sc * v;
        @(posedge clk);
        #1;
        case (slot)
            0: m_acc = t;
            1, 2, 3: m_acc = m_acc + t;
            4: begin
                sum    = m_acc + t;
                r.val  = (sum > SMAX) ? SMAX : ((sum < SMIN) ? SMIN : sum);
                r.clip = (sum > SMAX) || (sum < SMIN);
                r.cyc  = cyc + 1;
                exp_q.push_back(r);
                m_acc  = 0;
            end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_slot(5, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (mix_out !== '0 || mix_valid !== 1'b0 || mix_clip !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got out=%0d valid=%b clip=%b, want 0 0 0", mix_out, mix_valid, mix_clip);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        idle(2);
        total++;
        if (n_obs !== 0) begin
            bad++;
            $display("FAIL reset_quiet: got %0d pulses, want 0", n_obs);
        end
    endtask

    task automatic test_single;
        res_t e, o;
        drive_slot(0, 64, 64, 8, 1'b0);
        for (int s = 1; s < 5; s++) drive_slot(s, 64, 64, 8, 1'b1);
        idle(3);
        total++;
        if (n_obs - rd !== exp_q.size()) begin
            bad++;
            $display("FAIL single_count: got %0d pulses, want %0d", n_obs - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front(); o = obs[rd]; rd++; total++;
            if (o.val !== e.val || o.clip !== e.clip || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL single_frame: got val=%0d clip=%b cyc=%0d, want val=%0d clip=%b cyc=%0d", o.val, o.clip, o.cyc, e.val, e.clip, e.cyc);
            end
        end
        exp_q.delete(); rd = n_obs;
    endtask

    task automatic test_saturation;
        res_t e, o;
        for (int s = 0; s < 5; s++) drive_slot(s, 100, 127, 15, 1'b0);
        idle(1);
        for (int s = 0; s < 5; s++) drive_slot(s, -128, 127, 15, 1'b0);
        idle(1);
        for (int s = 0; s < 5; s++) drive_slot(s, -1, 1, 1, 1'b0);
        idle(3);
        total++;
        if (n_obs - rd !== exp_q.size()) begin
            bad++;
            $display("FAIL sat_count: got %0d pulses, want %0d", n_obs - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front(); o = obs[rd]; rd++; total++;
            if (o.val !== e.val || o.clip !== e.clip || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL sat_frame: got val=%0d clip=%b cyc=%0d, want val=%0d clip=%b cyc=%0d", o.val, o.clip, o.cyc, e.val, e.clip, e.cyc);
            end
        end
        exp_q.delete(); rd = n_obs;
    endtask

    task automatic test_bubbles;
        res_t e, o;
        int   seq[9] = '{0, 5, 1, 7, 2, 5, 3, 6, 4};
        foreach (seq[i]) drive_slot(seq[i], 64, 64, 8, seq[i] != 0);
        idle(3);
        total++;
        if (n_obs - rd !== exp_q.size()) begin
            bad++;
            $display("FAIL bubble_count: got %0d pulses, want %0d", n_obs - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front(); o = obs[rd]; rd++; total++;
            if (o.val !== e.val || o.clip !== e.clip || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL bubble_frame: got val=%0d clip=%b cyc=%0d, want val=%0d clip=%b cyc=%0d", o.val, o.clip, o.cyc, e.val, e.clip, e.cyc);
            end
        end
        exp_q.delete(); rd = n_obs;
    endtask

    task automatic test_restart;
        res_t e, o;
        for (int s = 0; s < 3; s++) drive_slot(s, 64, 64, 8, 1'b0);
        drive_slot(0, 64, 64, 8, 1'b0);
        for (int s = 1; s < 5; s++) drive_slot(s, 64, 64, 8, 1'b1);
        // Slot 4 with no slot 0 since the last close starts from zero.
        for (int s = 1; s < 5; s++) drive_slot(s, 64, 64, 8, 1'b0);
        idle(3);
        total++;
        if (n_obs - rd !== exp_q.size()) begin
            bad++;
            $display("FAIL restart_count: got %0d pulses, want %0d", n_obs - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front(); o = obs[rd]; rd++; total++;
            if (o.val !== e.val || o.clip !== e.clip || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL restart_frame: got val=%0d clip=%b cyc=%0d, want val=%0d clip=%b cyc=%0d", o.val, o.clip, o.cyc, e.val, e.clip, e.cyc);
            end
        end
        exp_q.delete(); rd = n_obs;
    endtask

    task automatic test_reset_midframe;
        res_t e, o;
        for (int s = 0; s < 5; s++) drive_slot(s, 100, 127, 15, 1'b0);
        idle(2);
        for (int s = 0; s < 3; s++) drive_slot(s, 100, 127, 15, 1'b0);
        nreset = 1'b0;
        #1;
        total++;
        if (mix_out !== '0 || mix_valid !== 1'b0 || mix_clip !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got out=%0d valid=%b clip=%b, want 0 0 0", mix_out, mix_valid, mix_clip);
        end
        m_acc = 0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int s = 1; s < 5; s++) drive_slot(s, 64, 64, 8, 1'b0);
        for (int s = 0; s < 5; s++) drive_slot(s, -37, 90, 11, 1'b0);
        idle(3);
        total++;
        if (n_obs - rd !== exp_q.size()) begin
            bad++;
            $display("FAIL rstmid_count: got %0d pulses, want %0d", n_obs - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front(); o = obs[rd]; rd++; total++;
            if (o.val !== e.val || o.clip !== e.clip || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL rstmid_frame: got val=%0d clip=%b cyc=%0d, want val=%0d clip=%b cyc=%0d", o.val, o.clip, o.cyc, e.val, e.clip, e.cyc);
            end
        end
        exp_q.delete(); rd = n_obs;
    endtask

    task automatic test_back_to_back;
        res_t e, o;
        for (int f = 0; f < 4; f++)
            for (int s = 0; s < 5; s++)
                drive_slot(s, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 127)),
                           int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        // Repeated slot index accumulates again.
        drive_slot(0, 64, 64, 8, 1'b0);
        drive_slot(1, 64, 64, 8, 1'b0);
        drive_slot(1, 64, 64, 8, 1'b0);
        drive_slot(4, 50, 127, 3, 1'b0);
        idle(3);
        total++;
        if (n_obs - rd !== exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d pulses, want %0d", n_obs - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front(); o = obs[rd]; rd++; total++;
            if (o.val !== e.val || o.clip !== e.clip || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL b2b_frame: got val=%0d clip=%b cyc=%0d, want val=%0d clip=%b cyc=%0d", o.val, o.clip, o.cyc, e.val, e.clip, e.cyc);
            end
        end
        exp_q.delete(); rd = n_obs;
    endtask

    initial begin
        nreset     = 1'b0;
        active     = 3'd5;
        wave       = '0;
        envelope   = '0;
        reg_volume = '0;
        ch_mute    = 1'b0;
        test_reset();
        test_single();
        test_saturation();
        test_bubbles();
        test_restart();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
